// File: rtl/dshot_pkg.sv
// Shared DShot frame constants, RX state encoding and the frame CRC helper.
package dshot_pkg;

    localparam int DSHOT_FRAME_BITS = 16;
    localparam int DSHOT_THR_MIN    = 48;
    localparam int THR_W            = 11;
    localparam int CRC_W            = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        CHECK = 2'd3
    } rx_state_t;

    // XOR of the three nibbles of {throttle, telemetry}
    function automatic logic [CRC_W-1:0] dshot_crc(input logic [DSHOT_FRAME_BITS-1:0] f);
        logic [11:0] v;
        v = f[15:4];
        dshot_crc = v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

endpackage

// File: rtl/dshot_pwm_bridge_if.sv
// Bus bundle between the flight-controller DShot pins and the PWM / blctrl consumers.
interface dshot_pwm_bridge_if #(
    parameter int NUM_CH  = 4,
    parameter int SPEED_W = 8
);
    logic [NUM_CH-1:0]         dshot_in;
    logic [NUM_CH-1:0]         pwm_out;
    logic [NUM_CH*SPEED_W-1:0] speed_flat;
    logic [NUM_CH-1:0]         frame_stb;
    logic [NUM_CH-1:0]         crc_err;
    logic [NUM_CH-1:0]         link_ok;

    modport master (
        output dshot_in,
        input  pwm_out, speed_flat, frame_stb, crc_err, link_ok
    );

    modport slave (
        input  dshot_in,
        output pwm_out, speed_flat, frame_stb, crc_err, link_ok
    );
endinterface

// File: rtl/dshot_rx_channel.sv
// One DShot receiver: synchroniser, bit FSM, CRC, throttle-to-speed mapping and failsafe timer.
// CRC rejection only exists when DSHOT_CRC_CHECK_EN is defined; otherwise every full frame is accepted.
module dshot_rx_channel
    import dshot_pkg::*;
#(
    parameter int SPEED_W     = 8,
    parameter int BIT_CLK     = 106,
    parameter int TIMEOUT_CLK = 800000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dshot_in,
    output logic [SPEED_W-1:0] speed,
    output logic               frame_stb,
    output logic               crc_err,
    output logic               link_ok
);

    localparam int HC_W = $clog2(2 * BIT_CLK + 2);
    localparam int TM_W = $clog2(TIMEOUT_CLK + 1);
    localparam int BC_W = $clog2(DSHOT_FRAME_BITS + 1);
    localparam logic [THR_W-1:0] SPD_MAX = THR_W'((1 << SPEED_W) - 1);

    logic [1:0]            sync_r;
    logic                  prev_r;
    rx_state_t             state_r;
    logic [HC_W-1:0]       hcnt_r;
    logic [BC_W-1:0]       bitcnt_r;
    logic [15:0]           shift_r;
    logic [TM_W-1:0]       timer_r;
    logic [SPEED_W-1:0]    speed_r;
    logic                  stb_r;
    logic                  err_r;
    logic                  link_r;

    logic                  line_s;
    logic                  rise_s;
    logic                  fall_s;
    logic                  bit_s;
    logic                  frame_ok_s;
    logic [THR_W-1:0]      thr_s;
    logic [THR_W-1:0]      thr_off_s;
    logic [THR_W-1:0]      scaled_s;
    logic [SPEED_W-1:0]    mapped_s;

    // Two-flop synchroniser plus delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], dshot_in};
            prev_r <= sync_r[1];
        end
    end

    // Edge detect, bit decision, CRC verdict and speed mapping
    always_comb begin
        line_s    = sync_r[1];
        rise_s    = line_s & ~prev_r;
        fall_s    = ~line_s & prev_r;
        bit_s     = (hcnt_r >= HC_W'(BIT_CLK / 2));
        thr_s     = shift_r[15:5];
        thr_off_s = thr_s - THR_W'(DSHOT_THR_MIN);
        scaled_s  = thr_off_s >> (THR_W - SPEED_W);
`ifdef DSHOT_CRC_CHECK_EN
        frame_ok_s = (shift_r[3:0] == dshot_crc(shift_r));
`else
        frame_ok_s = 1'b1;
`endif
        mapped_s = '0;
        if (thr_s < THR_W'(DSHOT_THR_MIN)) begin
            mapped_s = '0;
        end else if (scaled_s > SPD_MAX) begin
            mapped_s = SPD_MAX[SPEED_W-1:0];
        end else begin
            mapped_s = scaled_s[SPEED_W-1:0];
        end
    end

    // RX FSM with failsafe timer and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            hcnt_r   <= '0;
            bitcnt_r <= '0;
            shift_r  <= 16'h0000;
            timer_r  <= '0;
            speed_r  <= '0;
            stb_r    <= 1'b0;
            err_r    <= 1'b0;
            link_r   <= 1'b0;
        end else begin
            stb_r <= 1'b0;
            err_r <= 1'b0;
            // An accepted frame outranks expiry on the same cycle
            if (state_r == CHECK && frame_ok_s) begin
                timer_r <= TM_W'(TIMEOUT_CLK);
                link_r  <= 1'b1;
                speed_r <= mapped_s;
                stb_r   <= 1'b1;
            end else if (timer_r == '0) begin
                link_r  <= 1'b0;
                speed_r <= '0;
            end else begin
                timer_r <= timer_r - TM_W'(1);
            end
            if (state_r == CHECK && !frame_ok_s) begin
                err_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    bitcnt_r <= '0;
                    if (rise_s) begin
                        state_r <= HIGH;
                        hcnt_r  <= HC_W'(1);
                    end
                end
                HIGH: begin
                    if (fall_s) begin
                        shift_r  <= {shift_r[14:0], bit_s};
                        bitcnt_r <= bitcnt_r + BC_W'(1);
                        hcnt_r   <= '0;
                        state_r  <= (bitcnt_r == BC_W'(DSHOT_FRAME_BITS - 1)) ? CHECK : LOW;
                    end else if (hcnt_r > HC_W'(2 * BIT_CLK)) begin
                        state_r <= IDLE;
                    end else begin
                        hcnt_r <= hcnt_r + HC_W'(1);
                    end
                end
                LOW: begin
                    // hcnt_r doubles as the low-time counter here
                    if (bitcnt_r == BC_W'(DSHOT_FRAME_BITS)) begin
                        state_r <= CHECK;
                    end else if (rise_s) begin
                        state_r <= HIGH;
                        hcnt_r  <= HC_W'(1);
                    end else if (hcnt_r > HC_W'(2 * BIT_CLK)) begin
                        state_r <= IDLE;
                    end else begin
                        hcnt_r <= hcnt_r + HC_W'(1);
                    end
                end
                CHECK: begin
                    state_r  <= IDLE;
                    bitcnt_r <= '0;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign speed     = speed_r;
    assign frame_stb = stb_r;
    assign crc_err   = err_r;
    assign link_ok   = link_r;

endmodule

// File: rtl/dshot_pwm_bridge.sv
// NUM_CH DShot receivers feeding ESC PWM outputs through a shared frame counter.
// Build option: DSHOT_CRC_CHECK_EN enables CRC rejection inside each receiver.
module dshot_pwm_bridge
    import dshot_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int SPEED_W        = 8,
    parameter int BIT_CLK        = 106,
    parameter int PWM_PERIOD_CLK = 40000,
    parameter int PWM_MIN_CLK    = 16000,
    parameter int PWM_STEP_CLK   = 64,
    parameter int TIMEOUT_CLK    = 800000
) (
    input logic               clk,
    input logic               rst_n,
    dshot_pwm_bridge_if.slave bus
);

    localparam int PW_W = $clog2(PWM_PERIOD_CLK + 1);

    if (PWM_MIN_CLK + ((1 << SPEED_W) - 1) * PWM_STEP_CLK > PWM_PERIOD_CLK) begin : g_pw_check
        $error("dshot_pwm_bridge: maximum pulse exceeds PWM_PERIOD_CLK");
    end

    logic [PW_W-1:0]           cnt_r;
    logic [PW_W-1:0]           pw_r     [NUM_CH];
    logic [PW_W-1:0]           pw_new_s [NUM_CH];
    logic [PW_W-1:0]           pw_sel_s [NUM_CH];
    logic [NUM_CH-1:0]         pwm_r;
    logic [NUM_CH-1:0]         stb_s;
    logic [NUM_CH-1:0]         err_s;
    logic [NUM_CH-1:0]         link_s;
    logic [NUM_CH*SPEED_W-1:0] speed_s;
    logic                      wrap_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dshot_rx_channel #(
            .SPEED_W     (SPEED_W),
            .BIT_CLK     (BIT_CLK),
            .TIMEOUT_CLK (TIMEOUT_CLK)
        ) u_rx (
            .clk       (clk),
            .rst_n     (rst_n),
            .dshot_in  (bus.dshot_in[g]),
            .speed     (speed_s[g*SPEED_W +: SPEED_W]),
            .frame_stb (stb_s[g]),
            .crc_err   (err_s[g]),
            .link_ok   (link_s[g])
        );
    end

    // New pulse widths are only adopted on the wrap cycle so a pulse is never cut or stretched
    always_comb begin
        wrap_s = (cnt_r == '0);
        for (int g = 0; g < NUM_CH; g++) begin
            pw_new_s[g] = PW_W'(PWM_MIN_CLK)
                        + PW_W'(speed_s[g*SPEED_W +: SPEED_W]) * PW_W'(PWM_STEP_CLK);
            pw_sel_s[g] = wrap_s ? pw_new_s[g] : pw_r[g];
        end
    end

    // Shared period counter, per-channel width latch and registered compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            pwm_r <= '0;
            for (int g = 0; g < NUM_CH; g++) begin
                pw_r[g] <= '0;
            end
        end else begin
            cnt_r <= (cnt_r == PW_W'(PWM_PERIOD_CLK - 1)) ? '0 : cnt_r + PW_W'(1);
            for (int g = 0; g < NUM_CH; g++) begin
                if (wrap_s) begin
                    pw_r[g] <= pw_new_s[g];
                end
                pwm_r[g] <= (cnt_r < pw_sel_s[g]);
            end
        end
    end

    assign bus.pwm_out    = pwm_r;
    assign bus.speed_flat = speed_s;
    assign bus.frame_stb  = stb_s;
    assign bus.crc_err    = err_s;
    assign bus.link_ok    = link_s;

endmodule

// File: tb/tb_dshot_pwm_bridge.sv
// Directed bench for dshot_pwm_bridge with shortened timing parameters.
module tb_dshot_pwm_bridge;

    localparam int NCH   = 4;
    localparam int SW    = 8;
    localparam int BC    = 16;
    localparam int PER   = 1000;
    localparam int PMIN  = 400;
    localparam int PSTEP = 2;
    localparam int TMO   = 4000;
    localparam int HI1   = (3 * BC) / 4;
    localparam int HI0   = (3 * BC) / 8;
`ifdef DSHOT_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    typedef struct {
        int ch;
        int thr;
        int tlm;
        bit bad;
        int exp_on;
        int exp_off;
    } vec_t;

    localparam int NV = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dsh [NCH];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   stb_cnt [NCH] = '{default: 0};
    int   err_cnt [NCH] = '{default: 0};
    int   pw_meas [NCH] = '{default: 0};
    vec_t vecs [NV];

    dshot_pwm_bridge_if #(.NUM_CH(NCH), .SPEED_W(SW)) bus ();

    dshot_pwm_bridge #(
        .NUM_CH         (NCH),
        .SPEED_W        (SW),
        .BIT_CLK        (BC),
        .PWM_PERIOD_CLK (PER),
        .PWM_MIN_CLK    (PMIN),
        .PWM_STEP_CLK   (PSTEP),
        .TIMEOUT_CLK    (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < NCH; c++) bus.dshot_in[c] = dsh[c];
    end

    // Model of the PWM counter phase: posedges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            stb_cnt[c] <= stb_cnt[c] + (bus.frame_stb[c] ? 1 : 0);
            err_cnt[c] <= err_cnt[c] + (bus.crc_err[c] ? 1 : 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] mk_frame(input int thr, input int tlm, input bit bad);
        int v;
        int crc;
        v   = (thr << 1) | tlm;
        crc = (v ^ (v >> 4) ^ (v >> 8)) & 15;
        mk_frame = 16'((v << 4) | crc) ^ {15'd0, bad};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Drives n bits MSB first starting at the current negedge; the final low tail is optional
    task automatic send_bits(input int ch, input logic [15:0] f, input int n, input bit tail);
        for (int i = 0; i < n; i++) begin
            int hi;
            hi = f[15-i] ? HI1 : HI0;
            dsh[ch] = 1'b1;
            repeat (hi) @(negedge clk);
            dsh[ch] = 1'b0;
            if (tail || i != n - 1) repeat (BC - hi) @(negedge clk);
        end
    endtask

    // Counts high cycles of every channel over one full PWM frame starting at the next wrap
    task automatic measure_period();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * PER && !found; k++) begin
            if (cyc % PER == 1) found = 1'b1;
            else @(negedge clk);
        end
        chk("wrap_found", int'(found), 1);
        for (int c = 0; c < NCH; c++) pw_meas[c] = 0;
        for (int k = 0; k < PER; k++) begin
            for (int c = 0; c < NCH; c++) if (bus.pwm_out[c]) pw_meas[c]++;
            @(negedge clk);
        end
    endtask

    initial begin
        int s0;
        int e0;
        logic [15:0] f3;
        int hi15;
        bit aligned;

        vecs[0]  = '{0, 1048, 0, 1'b0, 125, 125};
        vecs[1]  = '{0, 1048, 0, 1'b1, 125, 125};
        vecs[2]  = '{0,   47, 0, 1'b0,   0,   0};
        vecs[3]  = '{0,   48, 0, 1'b0,   0,   0};
        vecs[4]  = '{0,   56, 0, 1'b0,   1,   1};
        vecs[5]  = '{0, 2047, 0, 1'b0, 249, 249};
        vecs[6]  = '{1,  500, 1, 1'b0,  56,  56};
        vecs[7]  = '{1, 1200, 0, 1'b1,  56, 144};
        vecs[8]  = '{2,   55, 0, 1'b0,   0,   0};
        vecs[9]  = '{3, 1000, 0, 1'b0, 119, 119};
        vecs[10] = '{2, 2000, 1, 1'b0, 244, 244};

        for (int c = 0; c < NCH; c++) dsh[c] = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_pwm_out",    int'(bus.pwm_out), 0);
        chk("rst_speed_flat", int'(bus.speed_flat), 0);
        chk("rst_frame_stb",  int'(bus.frame_stb), 0);
        chk("rst_crc_err",    int'(bus.crc_err), 0);
        chk("rst_link_ok",    int'(bus.link_ok), 0);
        rst_n = 1'b1;

        measure_period();
        for (int c = 0; c < NCH; c++) chk($sformatf("rst_pulse_ch%0d", c), pw_meas[c], PMIN);
        chk("rst_link_after", int'(bus.link_ok), 0);

        // Table of single frames
        for (int i = 0; i < NV; i++) begin
            int ch;
            int exp_spd;
            bit rejected;
            ch       = vecs[i].ch;
            s0       = stb_cnt[ch];
            e0       = err_cnt[ch];
            rejected = CRC_ON && vecs[i].bad;
            exp_spd  = CRC_ON ? vecs[i].exp_on : vecs[i].exp_off;
            send_bits(ch, mk_frame(vecs[i].thr, vecs[i].tlm, vecs[i].bad), 16, 1'b0);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d_speed", i), int'(bus.speed_flat[ch*SW +: SW]), exp_spd);
            chk($sformatf("vec%0d_stb", i), stb_cnt[ch] - s0, rejected ? 0 : 1);
            chk($sformatf("vec%0d_crc_err", i), err_cnt[ch] - e0, rejected ? 1 : 0);
            chk($sformatf("vec%0d_link", i), int'(bus.link_ok[ch]), 1);
            measure_period();
            chk($sformatf("vec%0d_pulse", i), pw_meas[ch], PMIN + exp_spd * PSTEP);
        end

        // Failsafe timeout, then recovery at full throttle
        repeat (TMO + 100) @(negedge clk);
        chk("tmo_link_ok", int'(bus.link_ok), 0);
        chk("tmo_speed_flat", int'(bus.speed_flat), 0);
        measure_period();
        chk("tmo_pulse_ch0", pw_meas[0], PMIN);
        send_bits(0, mk_frame(2047, 0, 1'b0), 16, 1'b0);
        repeat (20) @(negedge clk);
        chk("tmo_recover_speed", int'(bus.speed_flat[7:0]), 249);
        chk("tmo_recover_link", int'(bus.link_ok[0]), 1);
        measure_period();
        chk("tmo_recover_pulse", pw_meas[0], PMIN + 249 * PSTEP);

        // Partial frame followed by a long low gap must be discarded
        s0 = stb_cnt[0];
        e0 = err_cnt[0];
        send_bits(0, mk_frame(1048, 0, 1'b0), 7, 1'b1);
        repeat (100) @(negedge clk);
        send_bits(0, mk_frame(800, 0, 1'b0), 16, 1'b0);
        repeat (20) @(negedge clk);
        chk("partial_speed", int'(bus.speed_flat[7:0]), 94);
        chk("partial_stb", stb_cnt[0] - s0, 1);
        chk("partial_crc_err", err_cnt[0] - e0, 0);

        // Independent channels; channel 3 lands its speed update on the wrap cycle
        fork
            send_bits(0, mk_frame(300, 0, 1'b0), 16, 1'b0);
            send_bits(1, mk_frame(700, 0, 1'b0), 16, 1'b0);
            send_bits(2, mk_frame(1500, 0, 1'b0), 16, 1'b0);
        join
        repeat (10) @(negedge clk);
        f3      = mk_frame(1800, 0, 1'b0);
        hi15    = f3[0] ? HI1 : HI0;
        aligned = 1'b0;
        for (int k = 0; k < 2 * PER && !aligned; k++) begin
            if ((cyc + 15 * BC + hi15 + 3) % PER == 0) aligned = 1'b1;
            else @(negedge clk);
        end
        chk("wrap_align", int'(aligned), 1);
        send_bits(3, f3, 16, 1'b0);
        measure_period();
        chk("multi_p1_ch0", pw_meas[0], PMIN + 31 * PSTEP);
        chk("multi_p1_ch1", pw_meas[1], PMIN + 81 * PSTEP);
        chk("multi_p1_ch2", pw_meas[2], PMIN + 181 * PSTEP);
        chk("multi_p1_ch3", pw_meas[3], PMIN);
        measure_period();
        chk("multi_p2_ch0", pw_meas[0], PMIN + 31 * PSTEP);
        chk("multi_p2_ch3", pw_meas[3], PMIN + 219 * PSTEP);
        chk("multi_speed_ch3", int'(bus.speed_flat[31:24]), 219);

        // Reset in the middle of a frame and of a pulse
        aligned = 1'b0;
        for (int k = 0; k < 2 * PER && !aligned; k++) begin
            if (cyc % PER == 50) aligned = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_align", int'(aligned), 1);
        fork
            send_bits(0, mk_frame(1048, 0, 1'b0), 16, 1'b0);
        join_none
        repeat (150) @(negedge clk);
        chk("rst_mid_pwm_before", int'(bus.pwm_out[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pwm_out",    int'(bus.pwm_out), 0);
        chk("rst_mid_speed_flat", int'(bus.speed_flat), 0);
        chk("rst_mid_link_ok",    int'(bus.link_ok), 0);
        chk("rst_mid_frame_stb",  int'(bus.frame_stb), 0);
        chk("rst_mid_crc_err",    int'(bus.crc_err), 0);
        s0 = stb_cnt[0];
        e0 = err_cnt[0];
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("rst_mid_no_stb", stb_cnt[0] - s0, 0);
        chk("rst_mid_no_err", err_cnt[0] - e0, 0);
        chk("rst_mid_link_after", int'(bus.link_ok), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
